mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive dcache blocks granted while iREN waits before icache is forced in.
REQ-002 Parameter BLOCK_WORDS, default 2: RAM accesses per dcache block grant.
REQ-003 CLK  in  1  system clock, all state updates on rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 iREN  in  1  icache read request.
REQ-006 iaddr  in  32  icache word address.
REQ-007 iwait  out  1  icache stall; 0 only on the cycle its access completes.
REQ-008 iload  out  32  icache read data.
REQ-009 dREN, dWEN  in  1 each  dcache read/write request.
REQ-010 daddr, dstore  in  32 each  dcache address and write data.
REQ-011 dwait  out  1  dcache stall; 0 only on the cycle its access completes.
REQ-012 dload  out  32  dcache read data.
REQ-013 ramREN, ramWEN  out  1 each  RAM read/write strobe.
REQ-014 ramaddr, ramstore  out  32 each  RAM address and write data.
REQ-015 ramload  in  32  RAM read data.
REQ-016 ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Function
REQ-017 FSM states ARB_IDLE, ARB_D, ARB_I; registered state, combinational outputs.
REQ-018 ARB_IDLE: all ram* outputs 0, iwait=1, dwait=1.
REQ-019 ARB_IDLE -> ARB_D if (dREN|dWEN) and (!iREN or starve_cnt < STARVE_LIMIT).
REQ-020 ARB_IDLE -> ARB_I if iREN and not going to ARB_D; otherwise stay in ARB_IDLE.
REQ-021 Grant latency: exactly one cycle from request to ram strobe assertion.
REQ-022 ARB_D: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&!dWEN; dwait=(ramstate!=ACCESS); iwait=1.
REQ-023 ARB_D: word_cnt increments on each ACCESS; on ACCESS with word_cnt==BLOCK_WORDS-1, go to ARB_IDLE and clear word_cnt.
REQ-024 ARB_D: if dREN and dWEN are both 0 before block completion, go to ARB_IDLE next cycle and clear word_cnt.
REQ-025 ARB_I: ramaddr=iaddr, ramREN=1, ramWEN=0; iwait=(ramstate!=ACCESS); dwait=1; on ACCESS, go to ARB_IDLE.
REQ-026 ARB_I: iREN deasserted before ACCESS -> ARB_IDLE next cycle.
REQ-027 ramstate ERROR, BUSY, or FREE: not a completion; hold grant and stall.
REQ-028 iload=ramload and dload=ramload at all times; valid only on the owner's completion cycle.
REQ-029 starve_cnt: +1 on each dcache block completion (REQ-023) while iREN=1; saturates at STARVE_LIMIT; cleared on icache completion.
REQ-030 Priority: dcache wins simultaneous requests unless starve_cnt==STARVE_LIMIT.
REQ-031 A grant is never preempted mid-block; arbitration occurs only in ARB_IDLE.

Reset
REQ-032 nRST low: state=ARB_IDLE, word_cnt=0, starve_cnt=0, immediately and independent of CLK.
REQ-033 Reset mid-grant abandons the access; outputs return to REQ-018 values in the same cycle.

Structure
REQ-034 arb_state_t enum belongs in diaosi_types_pkg; ramstate_t and word_t come from cpu_types_pkg.
REQ-035 Single flat module, no sub-modules; word_cnt width $clog2(BLOCK_WORDS)+1, starve_cnt width $clog2(STARVE_LIMIT)+1.

Verification
REQ-036 iREN=1 only, iaddr=0x40, RAM ACCESS after 2 BUSY cycles -> ramREN rises cycle 1, iwait=0 cycle 3 with iload=ramload, then ARB_IDLE.
REQ-037 dWEN=1 daddr=0x80/0x84, dstore=0xDEAD/0xBEEF -> two RAM writes with matching address and data, dwait low once per word, then ARB_IDLE.
REQ-038 iREN and dREN asserted together from reset -> dcache granted first; icache granted immediately after the block.
REQ-039 dcache requests continuously and iREN held -> after 4 dcache blocks, icache granted; starve_cnt returns to 0.
REQ-040 nRST pulsed low during ARB_D with word_cnt=1 -> ram strobes 0 asynchronously; after release, a fresh 2-word block completes correctly.
REQ-041 ramstate=ERROR for 5 cycles during ARB_I -> iwait held 1, grant kept; ACCESS then completes normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM handshake status.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Status reported by the RAM model each cycle; only ACCESS completes a transfer.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Types local to the memory arbiter.
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_D    = 2'd1,
        ARB_I    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one RAM port between an icache (single-word reads)
// and a dcache (BLOCK_WORDS-word block transfers). The dcache wins
// simultaneous requests until it has completed STARVE_LIMIT blocks while the
// icache waited; the icache is then forced in. Grants are never preempted.
//
// Ports:
//   CLK, nRST             clock, asynchronous active-low reset
//   iREN, iaddr           icache read request and word address
//   iwait, iload          icache stall (low only on completion) and read data
//   dREN, dWEN            dcache read / write request
//   daddr, dstore         dcache address and write data
//   dwait, dload          dcache stall (low only on completion) and read data
//   ramREN, ramWEN        RAM read / write strobes
//   ramaddr, ramstore     RAM address and write data
//   ramload, ramstate     RAM read data and handshake status
//
// State is registered; the RAM and cache-side outputs decode combinationally
// from the state so a grant drives the RAM one cycle after the request.
module mem_arbiter
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned BLOCK_WORDS  = 2
) (
    input  logic        CLK,
    input  logic        nRST,

    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,

    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,

    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam int unsigned WCW = $clog2(BLOCK_WORDS) + 1;
    localparam int unsigned SCW = $clog2(STARVE_LIMIT) + 1;

    arb_state_t     state;
    logic [WCW-1:0] word_cnt;
    logic [SCW-1:0] starve_cnt;

    logic d_req;
    logic go_d;
    logic ram_done;
    logic last_word;
    logic starved;

    assign d_req     = dREN | dWEN;
    assign ram_done  = (ramstate == 2'(ACCESS));
    assign last_word = (word_cnt == WCW'(BLOCK_WORDS - 1));
    assign starved   = (starve_cnt >= SCW'(STARVE_LIMIT));
    // dcache keeps priority until the icache has been starved long enough.
    assign go_d      = d_req & (~iREN | ~starved);

    // Read data is broadcast; each cache samples it on its own completion cycle.
    assign iload = ramload;
    assign dload = ramload;

    // State, beat counter and starvation counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= ARB_IDLE;
            word_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (go_d) begin
                        state <= ARB_D;
                    end else if (iREN) begin
                        state <= ARB_I;
                    end
                end

                ARB_D: begin
                    // A dropped request abandons the rest of the block.
                    if (!d_req) begin
                        state    <= ARB_IDLE;
                        word_cnt <= '0;
                    end else if (ram_done) begin
                        if (last_word) begin
                            state    <= ARB_IDLE;
                            word_cnt <= '0;
                            if (iREN && !starved) begin
                                starve_cnt <= starve_cnt + SCW'(1);
                            end
                        end else begin
                            word_cnt <= word_cnt + WCW'(1);
                        end
                    end
                end

                ARB_I: begin
                    if (!iREN) begin
                        state <= ARB_IDLE;
                    end else if (ram_done) begin
                        state      <= ARB_IDLE;
                        starve_cnt <= '0;
                    end
                end

                default: begin
                    state    <= ARB_IDLE;
                    word_cnt <= '0;
                end
            endcase
        end
    end

    // Output decode from the current owner.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            ARB_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~ram_done;
            end
            ARB_I: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                iwait   = ~ram_done;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the RAM status is driven by hand each cycle
// and every output is compared against hand-computed values.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int vecs = 0;
    int errs = 0;

    mem_arbiter #(.STARVE_LIMIT(4), .BLOCK_WORDS(2)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    localparam logic [1:0] RS_FREE   = 2'(FREE);
    localparam logic [1:0] RS_BUSY   = 2'(BUSY);
    localparam logic [1:0] RS_ACCESS = 2'(ACCESS);
    localparam logic [1:0] RS_ERROR  = 2'(ERROR);

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;
        #3;
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_iwait",  32'(iwait),  32'd1);
        chk("rst_dwait",  32'(dwait),  32'd1);
        chk("rst_ramaddr", ramaddr, 32'h0);
        step(); step();
        nRST = 1'b1;

        // icache read, two BUSY cycles then ACCESS
        iREN = 1'b1; iaddr = 32'h40; ramstate = RS_BUSY;
        #2 chk("i_c0_ramREN", 32'(ramREN), 32'd0);
        step();
        #2 chk("i_c1_ramREN", 32'(ramREN), 32'd1);
        chk("i_c1_ramaddr", ramaddr, 32'h40);
        chk("i_c1_iwait", 32'(iwait), 32'd1);
        step();
        #2 chk("i_c2_iwait", 32'(iwait), 32'd1);
        step();
        ramstate = RS_ACCESS; ramload = 32'h1234_5678;
        #2 chk("i_c3_iwait", 32'(iwait), 32'd0);
        chk("i_c3_iload", iload, 32'h1234_5678);
        chk("i_c3_dwait", 32'(dwait), 32'd1);
        step();
        iREN = 1'b0; ramstate = RS_FREE;
        #2 chk("i_idle_ramREN", 32'(ramREN), 32'd0);
        chk("i_idle_iwait", 32'(iwait), 32'd1);

        // dcache two-word write block
        dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD;
        #2 chk("dw_c0_ramWEN", 32'(ramWEN), 32'd0);
        step();
        #2 chk("dw_w0_ramWEN", 32'(ramWEN), 32'd1);
        chk("dw_w0_ramREN", 32'(ramREN), 32'd0);
        chk("dw_w0_ramaddr", ramaddr, 32'h80);
        chk("dw_w0_ramstore", ramstore, 32'hDEAD);
        chk("dw_w0_dwait_busy", 32'(dwait), 32'd1);
        step();
        ramstate = RS_ACCESS;
        #2 chk("dw_w0_dwait", 32'(dwait), 32'd0);
        step();
        daddr = 32'h84; dstore = 32'hBEEF; ramstate = RS_BUSY;
        #2 chk("dw_w1_dwait_busy", 32'(dwait), 32'd1);
        chk("dw_w1_ramaddr", ramaddr, 32'h84);
        step();
        ramstate = RS_ACCESS;
        #2 chk("dw_w1_dwait", 32'(dwait), 32'd0);
        chk("dw_w1_ramstore", ramstore, 32'hBEEF);
        chk("dw_w1_ramWEN", 32'(ramWEN), 32'd1);
        step();
        ramstate = RS_FREE;
        // dWEN still high: still in IDLE this cycle, so no strobe
        #2 chk("dw_idle_ramWEN", 32'(ramWEN), 32'd0);
        chk("dw_idle_dwait", 32'(dwait), 32'd1);
        dWEN = 1'b0;
        step();

        // Simultaneous requests from a fresh reset: dcache first
        nRST = 1'b0; #1 nRST = 1'b1;
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h100; iaddr = 32'h200;
        #1 chk("sim_idle_ramREN", 32'(ramREN), 32'd0);
        step();
        #2 chk("sim_d_ramREN", 32'(ramREN), 32'd1);
        chk("sim_d_ramaddr", ramaddr, 32'h100);
        chk("sim_d_iwait", 32'(iwait), 32'd1);
        step();
        ramstate = RS_ACCESS; ramload = 32'h1111;
        #2 chk("sim_d_dwait0", 32'(dwait), 32'd0);
        chk("sim_d_dload", dload, 32'h1111);
        chk("sim_d_iwait0", 32'(iwait), 32'd1);
        step();
        ramstate = RS_FREE; daddr = 32'h104;
        #2 chk("sim_d_ramaddr1", ramaddr, 32'h104);
        step();
        ramstate = RS_ACCESS;
        #2 chk("sim_d_dwait1", 32'(dwait), 32'd0);
        step();
        dREN = 1'b0; ramstate = RS_FREE;
        #2 chk("sim_idle2_ramREN", 32'(ramREN), 32'd0);
        step();
        #2 chk("sim_i_ramaddr", ramaddr, 32'h200);
        chk("sim_i_ramREN", 32'(ramREN), 32'd1);
        step();
        ramstate = RS_ACCESS; ramload = 32'h2222;
        #2 chk("sim_i_iwait", 32'(iwait), 32'd0);
        chk("sim_i_iload", iload, 32'h2222);
        step();
        iREN = 1'b0; ramstate = RS_FREE;
        #2 chk("sim_end_iwait", 32'(iwait), 32'd1);

        // Starvation: four dcache blocks, then icache forced in
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h300; iaddr = 32'h400;
        ramstate = RS_ACCESS;
        for (int b = 0; b < 4; b++) begin
            #2 chk($sformatf("stv_idle%0d_ramREN", b), 32'(ramREN), 32'd0);
            step();
            #2 chk($sformatf("stv_d%0d_ramaddr", b), ramaddr, 32'h300);
            chk($sformatf("stv_d%0d_dwait0", b), 32'(dwait), 32'd0);
            step();
            #2 chk($sformatf("stv_d%0d_dwait1", b), 32'(dwait), 32'd0);
            step();
        end
        #2 chk("stv_idle4_ramREN", 32'(ramREN), 32'd0);
        step();
        #2 chk("stv_i_ramaddr", ramaddr, 32'h400);
        chk("stv_i_iwait", 32'(iwait), 32'd0);
        chk("stv_i_dwait", 32'(dwait), 32'd1);
        step();
        #2 chk("stv_idle5_ramREN", 32'(ramREN), 32'd0);
        step();
        // starvation count cleared: dcache wins again
        #2 chk("stv_d_again_ramaddr", ramaddr, 32'h300);
        // request dropped mid-block returns to IDLE
        dREN = 1'b0; iREN = 1'b0; ramstate = RS_FREE;
        step();
        dREN = 1'b1;
        #2 chk("drop_idle_ramREN", 32'(ramREN), 32'd0);
        dREN = 1'b0;
        step();

        // Reset in the middle of a dcache block
        dWEN = 1'b1; daddr = 32'h500; dstore = 32'hA5A5;
        step();
        ramstate = RS_ACCESS;
        #2 chk("rstm_w0_dwait", 32'(dwait), 32'd0);
        step();
        ramstate = RS_BUSY;
        #2 chk("rstm_w1_ramWEN", 32'(ramWEN), 32'd1);
        nRST = 1'b0;
        #1 chk("rstm_async_ramWEN", 32'(ramWEN), 32'd0);
        chk("rstm_async_ramREN", 32'(ramREN), 32'd0);
        chk("rstm_async_dwait", 32'(dwait), 32'd1);
        @(negedge CLK);
        #1 nRST = 1'b1;
        step();
        #2 chk("rstm_new_ramWEN", 32'(ramWEN), 32'd1);
        chk("rstm_new_ramaddr", ramaddr, 32'h500);
        ramstate = RS_ACCESS;
        #1 chk("rstm_new_w0_dwait", 32'(dwait), 32'd0);
        step();
        daddr = 32'h504; dstore = 32'h5A5A;
        #2 chk("rstm_new_w1_dwait", 32'(dwait), 32'd0);
        chk("rstm_new_w1_ramstore", ramstore, 32'h5A5A);
        step();
        #2 chk("rstm_done_ramWEN", 32'(ramWEN), 32'd0);
        dWEN = 1'b0; ramstate = RS_FREE;
        step();

        // ERROR during an icache grant holds the stall
        iREN = 1'b1; iaddr = 32'h600; ramstate = RS_ERROR;
        step();
        for (int k = 0; k < 5; k++) begin
            #2 chk($sformatf("err%0d_iwait", k), 32'(iwait), 32'd1);
            chk($sformatf("err%0d_ramaddr", k), ramaddr, 32'h600);
            step();
        end
        ramstate = RS_ACCESS; ramload = 32'hCAFE_F00D;
        #2 chk("err_done_iwait", 32'(iwait), 32'd0);
        chk("err_done_iload", iload, 32'hCAFE_F00D);
        step();
        iREN = 1'b0; ramstate = RS_FREE;
        #2 chk("err_idle_ramREN", 32'(ramREN), 32'd0);

        // icache request withdrawn before completion
        iREN = 1'b1; iaddr = 32'h700; ramstate = RS_BUSY;
        step();
        #2 chk("iwd_ramREN", 32'(ramREN), 32'd1);
        iREN = 1'b0;
        step();
        iREN = 1'b1;
        #2 chk("iwd_idle_ramREN", 32'(ramREN), 32'd0);
        iREN = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
